// File: rtl/input_debouncer_if.sv
// Raw and debounced button/switch signals between the board pins and the debouncer.
// The slave modport is the debouncer side; the master modport is the side that drives the raw inputs.
interface input_debouncer_if;
    logic       button_n;
    logic [3:0] switch_raw;
    logic [3:0] switch;
    logic       button;
    logic       button_press;
    logic       button_release;
    logic       switch_changed;

    modport slave (
        input  button_n,
        input  switch_raw,
        output switch,
        output button,
        output button_press,
        output button_release,
        output switch_changed
    );

    modport master (
        output button_n,
        output switch_raw,
        input  switch,
        input  button,
        input  button_press,
        input  button_release,
        input  switch_changed
    );
endinterface

// File: rtl/input_debouncer.sv
// Five-channel debouncer (4 switches + 1 button): 2-flop sync, then STABLE_CYCLES agreement; level lands STABLE_CYCLES+1 edges after first sample.
// Inputs are level signals with no backpressure; every output is registered and edge pulses last one cycle.
module input_debouncer #(
    parameter int STABLE_CYCLES = 50000
) (
    input  logic              clock,
    input  logic              reset,
    input_debouncer_if.slave  bus
);
    localparam int NCH = 5;
    localparam int CW  = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    // Bit 4 is the button, inverted up front so every channel is active-high.
    logic [NCH-1:0] raw;
    logic [NCH-1:0] sync1;
    logic [NCH-1:0] sync2;
    logic [NCH-1:0] stable;
    logic [NCH-1:0] stable_nxt;
    logic [CW-1:0]  cnt     [NCH];
    logic [CW-1:0]  cnt_nxt [NCH];
    logic           press_q;
    logic           release_q;
    logic           changed_q;

    assign raw = {~bus.button_n, bus.switch_raw};

    always_comb begin
        stable_nxt = stable;
        for (int i = 0; i < NCH; i++) begin
            cnt_nxt[i] = '0;
            if (sync2[i] != stable[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    stable_nxt[i] = sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            stable    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            changed_q <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1     <= raw;
            sync2     <= sync1;
            stable    <= stable_nxt;
            press_q   <= stable_nxt[4] & ~stable[4];
            release_q <= ~stable_nxt[4] & stable[4];
            changed_q <= |(stable_nxt[3:0] ^ stable[3:0]);
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    assign bus.switch         = stable[3:0];
    assign bus.button         = stable[4];
    assign bus.button_press   = press_q;
    assign bus.button_release = release_q;
    assign bus.switch_changed = changed_q;
endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer with STABLE_CYCLES=4: directed scenarios with literal expectations plus
// randomized bouncing inputs compared every cycle against a window-based reference model.
module tb_input_debouncer;
    localparam int SC = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    input_debouncer_if bus();

    input_debouncer #(.STABLE_CYCLES(SC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Reference model: a channel's level flips once the last SC synchronized samples seen since reset all disagree with it.
    logic [4:0] m_s1 = '0;
    logic [4:0] m_s2 = '0;
    logic [4:0] m_stab = '0;
    logic       m_press = 1'b0;
    logic       m_rel = 1'b0;
    logic       m_chg = 1'b0;
    logic [4:0] hist[$];

    task automatic model_step();
        logic [4:0] d;
        logic [4:0] upd;
        logic [4:0] nxt;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_stab = '0;
            m_press = 1'b0; m_rel = 1'b0; m_chg = 1'b0;
            hist.delete();
        end else begin
            d = m_s2;
            m_s2 = m_s1;
            m_s1 = {~bus.button_n, bus.switch_raw};
            hist.push_back(d);
            if (hist.size() > SC) void'(hist.pop_front());
            upd = '0;
            if (hist.size() == SC) begin
                for (int i = 0; i < 5; i++) begin
                    upd[i] = 1'b1;
                    foreach (hist[j]) if (hist[j][i] == m_stab[i]) upd[i] = 1'b0;
                end
            end
            nxt     = m_stab ^ upd;
            m_press = upd[4] & nxt[4];
            m_rel   = upd[4] & ~nxt[4];
            m_chg   = |upd[3:0];
            m_stab  = nxt;
        end
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clock);
        if (cmp_en) begin
            check("cyc_switch",  32'(bus.switch),         32'(m_stab[3:0]));
            check("cyc_button",  32'(bus.button),         32'(m_stab[4]));
            check("cyc_press",   32'(bus.button_press),   32'(m_press));
            check("cyc_release", 32'(bus.button_release), 32'(m_rel));
            check("cyc_changed", 32'(bus.switch_changed), 32'(m_chg));
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    int hold;
    int chg_cnt;
    logic prev_bit;

    initial begin
        bus.button_n   = 1'b1;
        bus.switch_raw = 4'b0000;
        reset = 1'b1;
        step();
        cmp_en = 1'b1;
        step();
        step();
        check("reset_switch", 32'(bus.switch), 32'h0);
        check("reset_button", 32'(bus.button), 32'h0);
        check("reset_pulses", 32'({bus.button_press, bus.button_release, bus.switch_changed}), 32'h0);
        reset = 1'b0;
        repeat (8) step();

        // 0000 -> 0101 held: update exactly at edge k+5
        bus.switch_raw = 4'b0101;
        step();
        for (int e = 1; e <= 4; e++) begin
            step();
            check("sw_early", 32'(bus.switch), 32'h0);
            check("sw_early_chg", 32'(bus.switch_changed), 32'h0);
        end
        step();
        check("sw_k5", 32'(bus.switch), 32'h5);
        check("sw_k5_chg", 32'(bus.switch_changed), 32'h1);
        check("sw_k5_model", 32'(m_stab[3:0]), 32'h5);
        step();
        check("sw_chg_one_cycle", 32'(bus.switch_changed), 32'h0);

        // 3-cycle button bounce is discarded
        bus.button_n = 1'b0;
        repeat (3) step();
        bus.button_n = 1'b1;
        for (int e = 0; e < 10; e++) begin
            step();
            check("bounce_button", 32'(bus.button), 32'h0);
            check("bounce_press", 32'(bus.button_press), 32'h0);
        end

        // held press for 20 cycles, then release
        bus.button_n = 1'b0;
        step();
        for (int e = 1; e <= 4; e++) begin
            step();
            check("press_early", 32'(bus.button), 32'h0);
        end
        step();
        check("press_k5", 32'(bus.button_press), 32'h1);
        check("press_level", 32'(bus.button), 32'h1);
        check("press_model", 32'(m_press), 32'h1);
        step();
        check("press_one_cycle", 32'(bus.button_press), 32'h0);
        repeat (13) step();
        bus.button_n = 1'b1;
        step();
        for (int e = 1; e <= 4; e++) begin
            step();
            check("rel_early", 32'(bus.button), 32'h1);
            check("rel_early_pulse", 32'(bus.button_release), 32'h0);
        end
        step();
        check("rel_k5", 32'(bus.button_release), 32'h1);
        check("rel_level", 32'(bus.button), 32'h0);
        step();
        check("rel_one_cycle", 32'(bus.button_release), 32'h0);

        // switch_raw[2] toggles every 2 cycles then holds 1
        bus.switch_raw = 4'b0000;
        repeat (10) step();
        check("sw_cleared", 32'(bus.switch), 32'h0);
        chg_cnt = 0;
        prev_bit = bus.switch[2];
        for (int c = 0; c < 40; c++) begin
            bus.switch_raw[2] = ((c / 2) % 2 == 0);
            step();
            if (bus.switch[2] != prev_bit) chg_cnt++;
            prev_bit = bus.switch[2];
        end
        check("toggle_no_change", 32'(chg_cnt), 32'd0);
        bus.switch_raw[2] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (bus.switch[2] != prev_bit) chg_cnt++;
            prev_bit = bus.switch[2];
        end
        check("toggle_one_change", 32'(chg_cnt), 32'd1);
        check("toggle_final", 32'(bus.switch), 32'h4);

        // reset lands mid-count with switches at 1111
        bus.switch_raw = 4'b1111;
        repeat (4) step();
        reset = 1'b1;
        step();
        step();
        check("midrst_switch", 32'(bus.switch), 32'h0);
        check("midrst_pulses", 32'({bus.button, bus.button_press, bus.button_release, bus.switch_changed}), 32'h0);
        reset = 1'b0;
        step();
        for (int e = 1; e <= 4; e++) begin
            step();
            check("postrst_early", 32'(bus.switch), 32'h0);
            check("postrst_early_chg", 32'(bus.switch_changed), 32'h0);
        end
        step();
        check("postrst_switch", 32'(bus.switch), 32'hF);
        check("postrst_chg", 32'(bus.switch_changed), 32'h1);
        step();
        check("postrst_chg_once", 32'(bus.switch_changed), 32'h0);

        // switch bit 0 and button change on the same edge
        bus.switch_raw = 4'b1110;
        bus.button_n   = 1'b0;
        step();
        repeat (4) step();
        step();
        check("same_edge_chg", 32'(bus.switch_changed), 32'h1);
        check("same_edge_press", 32'(bus.button_press), 32'h1);
        check("same_edge_switch", 32'(bus.switch), 32'hE);
        check("same_edge_model", 32'({m_chg, m_press}), 32'h3);
        bus.button_n = 1'b1;
        repeat (8) step();

        // randomized bouncing with occasional resets
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 499) == 0);
            if (hold == 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.switch_raw = 4'($urandom);
                end else begin
                    int b;
                    b = $urandom_range(0, 3);
                    bus.switch_raw[b] = ~bus.switch_raw[b];
                end
                if ($urandom_range(0, 2) == 0) bus.button_n = ~bus.button_n;
                hold = $urandom_range(1, 8);
            end
            hold--;
            step();
        end
        reset = 1'b0;
        repeat (10) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
